iter_shifter: RTL and testbench

- Parametrised, multi-cycle shift unit for the execute stage. Successor to the fixed shift-by-2 used in branch-target computation.
- Supports variable shift amount and SLL/SRL/SRA modes, with optional rotate.
- Shifts up to STEP bits per cycle under a start/done handshake, trading latency for area versus a full barrel shifter.

---
 rtl/iter_shifter.sv | 118 +++++++++++
 tb/tb_iter_shifter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle variable shifter (SLL/SRL/SRA, optional ROTL).
// Shifts at most STEP bits per cycle under a start/done handshake.
// Optional feature macro: ITER_SHIFTER_ROTATE_EN. When it is defined,
// mode 11 rotates left. When it is undefined, mode 11 behaves as SLL.
module iter_shifter #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHAMT_W = 5,
   parameter int unsigned STEP    = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic [1:0]         mode,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   out_data
);

   // The counter is one bit wider so that STEP == WIDTH still fits.
   localparam int unsigned CNT_W = SHAMT_W + 1;
   localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic [SHAMT_W-1:0] rem_q, rem_d;
   logic [1:0]         mode_q, mode_d;
   logic               load_out;
   logic [CNT_W-1:0]   step_amt;
   logic [WIDTH-1:0]   shifted;
`ifdef ITER_SHIFTER_ROTATE_EN
   logic [CNT_W-1:0]   rot_amt;
`endif

   // Per-cycle step is min(remaining, STEP).
   assign step_amt = ({1'b0, rem_q} < STEP_C) ? {1'b0, rem_q} : STEP_C;

`ifdef ITER_SHIFTER_ROTATE_EN
   // Bits rotated out of the MSB re-enter at the LSB. A zero step gives a zero right-shift.
   assign rot_amt = CNT_W'(WIDTH) - step_amt;
`endif

   // One shift step of the data register, using the captured mode.
   always_comb begin
      shifted = data_q << step_amt;
      case (mode_q)
         2'b01:   shifted = data_q >> step_amt;
         2'b10:   shifted = $unsigned($signed(data_q) >>> step_amt);
`ifdef ITER_SHIFTER_ROTATE_EN
         2'b11:   shifted = (data_q << step_amt) | (data_q >> rot_amt);
`endif
         default: shifted = data_q << step_amt;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic and next values of the datapath registers.
   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      rem_d    = rem_q;
      mode_d   = mode_q;
      load_out = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               data_d  = in_data;
               rem_d   = shamt;
               mode_d  = mode;
               state_d = SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            data_d = shifted;
            rem_d  = rem_q - SHAMT_W'(step_amt);
            if (rem_d == '0) begin
               state_d  = DONE;
               load_out = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath registers and registered outputs. out_data changes only on entry to DONE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q   <= '0;
         rem_q    <= '0;
         mode_q   <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         out_data <= '0;
      end else begin
         data_q <= data_d;
         rem_q  <= rem_d;
         mode_q <= mode_d;
         busy   <= (state_d == SHIFT);
         done   <= (state_d == DONE);
         if (load_out) out_data <= data_d;
      end
   end

endmodule

// File: tb/tb_iter_shifter.sv
// Directed self-checking bench for iter_shifter (WIDTH=32, STEP=4).
// The rotate expectations follow the ITER_SHIFTER_ROTATE_EN macro.
module tb_iter_shifter;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] in_data;
   logic [4:0]  shamt;
   logic [1:0]  mode;
   logic        busy;
   logic        done;
   logic [31:0] out_data;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] last_out = 32'h0;

   iter_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .in_data  (in_data),
      .shamt    (shamt),
      .mode     (mode),
      .busy     (busy),
      .done     (done),
      .out_data (out_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Launch one operation and check busy, the held output, latency and result.
   // The task returns at the negedge of the done cycle.
   task automatic run_op(input string tag, input logic [31:0] d, input logic [4:0] s,
                         input logic [1:0] m, input logic [31:0] exp, input int lat);
      int n;
      @(negedge clk);
      start = 1'b1; in_data = d; shamt = s; mode = m;
      @(negedge clk);
      start = 1'b0; in_data = 32'h5A5A_A5A5; shamt = 5'h1F; mode = 2'b10;
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_hold"}, out_data, last_out);
      n = 1;
      while (done !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_lat"}, 32'(n), 32'(lat));
      chk({tag, "_out"}, out_data, exp);
      chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      last_out = exp;
   endtask

   initial begin
      int n;
      int seen;
      reset = 1'b1; start = 1'b0; in_data = '0; shamt = '0; mode = '0;
      #12;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_out", out_data, 32'h0);
      @(negedge clk);
      reset = 1'b0;

      run_op("sll2",   32'h0000_0001, 5'd2,  2'b00, 32'h0000_0004, 2);
      run_op("sra31",  32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF, 9);
      run_op("srl31",  32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001, 9);
      run_op("sra5",   32'h8000_0000, 5'd5,  2'b10, 32'hFC00_0000, 3);
      run_op("zero",   32'hDEAD_BEEF, 5'd0,  2'b00, 32'hDEAD_BEEF, 2);
      run_op("srl8",   32'hDEAD_BEEF, 5'd8,  2'b01, 32'h00DE_ADBE, 3);

      // Back-to-back: start while in DONE is accepted without an IDLE cycle.
      start = 1'b1; in_data = 32'h0000_00F0; shamt = 5'd4; mode = 2'b01;
      @(negedge clk);
      start = 1'b0;
      chk("b2b_busy", 32'(busy), 32'd1);
      chk("b2b_done_low", 32'(done), 32'd0);
      @(negedge clk);
      chk("b2b_done", 32'(done), 32'd1);
      chk("b2b_out", out_data, 32'h0000_000F);
      last_out = 32'h0000_000F;

`ifdef ITER_SHIFTER_ROTATE_EN
      run_op("rot4", 32'h8000_0001, 5'd4, 2'b11, 32'h0000_0018, 2);
      run_op("rot9", 32'h8000_0001, 5'd9, 2'b11, 32'h0000_0300, 4);
`else
      run_op("rot4", 32'h8000_0001, 5'd4, 2'b11, 32'h0000_0010, 2);
      run_op("rot9", 32'h8000_0001, 5'd9, 2'b11, 32'h0000_0200, 4);
`endif

      // A start pulse during SHIFT is ignored and nothing is queued.
      @(negedge clk);
      start = 1'b1; in_data = 32'h0000_0001; shamt = 5'd31; mode = 2'b00;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      while (done !== 1'b1 && n < 40) begin
         if (n == 3) begin
            start = 1'b1; in_data = 32'hFFFF_FFFF; shamt = 5'd1; mode = 2'b01;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      chk("ign_lat", 32'(n), 32'd9);
      chk("ign_out", out_data, 32'h8000_0000);
      @(negedge clk);
      chk("ign_no_queue_busy", 32'(busy), 32'd0);
      chk("ign_no_queue_done", 32'(done), 32'd0);
      last_out = 32'h8000_0000;

      // Reset mid-SHIFT aborts the operation with no done pulse.
      @(negedge clk);
      start = 1'b1; in_data = 32'h0000_0001; shamt = 5'd20; mode = 2'b00;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_out", out_data, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) seen++;
      end
      chk("midrst_no_done", 32'(seen), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
